// File: rtl/fx3_tx_arbiter.sv
// ============================================================================
// fx3_tx_arbiter : packet round-robin arbiter for two 16-bit stream sources
//                  onto the FX3 TX path, with a source-ID header per grant.
// Revision       : 1.0 - initial release
// ============================================================================
`default_nettype none

module fx3_tx_arbiter #(
  parameter int MAX_LEN = 256,
  parameter int CW      = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic [15:0] s0_data_i,
  input  logic        s0_valid_i,
  input  logic        s0_last_i,
  output logic        s0_ready_o,
  input  logic [15:0] s1_data_i,
  input  logic        s1_valid_i,
  input  logic        s1_last_i,
  output logic        s1_ready_o,
  output logic [15:0] m_data_o,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic [1:0]  grant_o,
  output logic        busy_o
);

  localparam logic [CW-1:0] C_CNT_LAST = CW'(MAX_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t         r_state;
  logic           r_src;
  logic           r_rr_last;
  logic [CW-1:0]  r_cnt;
  logic [1:0]     r_grant;
  logic           r_busy;
  logic [15:0]    r_hdr;

  logic [15:0]    w_sel_data;
  logic           w_sel_valid;
  logic           w_sel_last;
  logic           w_pick;
  logic           w_xfer;
  logic           w_eob;

  always_comb begin
    w_sel_data  = r_src ? s1_data_i  : s0_data_i;
    w_sel_valid = r_src ? s1_valid_i : s0_valid_i;
    w_sel_last  = r_src ? s1_last_i  : s0_last_i;
  end

  // On a tie the source that did not own the previous burst wins.
  assign w_pick = (s0_valid_i && s1_valid_i) ? ~r_rr_last : s1_valid_i;
  assign w_xfer = (r_state == S_DATA) && w_sel_valid && m_ready_i;
  assign w_eob  = w_xfer && (w_sel_last || (r_cnt == C_CNT_LAST));

  always_comb begin
    m_valid_o = 1'b0;
    m_data_o  = 16'h0000;
    case (r_state)
      S_HDR: begin
        m_valid_o = 1'b1;
        m_data_o  = r_hdr;
      end
      S_DATA: begin
        m_valid_o = w_sel_valid;
        m_data_o  = w_sel_data;
      end
      default: begin
        m_valid_o = 1'b0;
        m_data_o  = 16'h0000;
      end
    endcase
  end

  assign s0_ready_o = (r_state == S_DATA) && !r_src && m_ready_i;
  assign s1_ready_o = (r_state == S_DATA) &&  r_src && m_ready_i;
  assign grant_o    = r_grant;
  assign busy_o     = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_src     <= 1'b0;
      r_rr_last <= 1'b1;
      r_cnt     <= '0;
      r_grant   <= 2'b00;
      r_busy    <= 1'b0;
      r_hdr     <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (en_i && (s0_valid_i || s1_valid_i)) begin
            r_src   <= w_pick;
            r_hdr   <= {4'hA, 3'b000, w_pick, 8'h00};
            r_grant <= w_pick ? 2'b10 : 2'b01;
            r_busy  <= 1'b1;
            r_state <= S_HDR;
          end
        end
        S_HDR: begin
          if (m_ready_i) begin
            r_cnt   <= '0;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_eob) begin
            r_cnt     <= '0;
            r_rr_last <= r_src;
            r_grant   <= 2'b00;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else if (w_xfer) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fx3_tx_arbiter.sv
// ============================================================================
// tb_fx3_tx_arbiter : directed bench with a packet-level stream model.
// Revision          : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fx3_tx_arbiter;

  localparam int MAXL = 4;

  typedef struct packed {
    logic        hdr;
    logic        eob;
    logic        src;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_i;
  logic [15:0] s0_data_i, s1_data_i;
  logic        s0_valid_i, s1_valid_i, s0_last_i, s1_last_i;
  logic        s0_ready_o, s1_ready_o;
  logic [15:0] m_data_o;
  logic        m_valid_o, m_ready_i;
  logic [1:0]  grant_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [16:0] q0[$];
  logic [16:0] q1[$];
  exp_t        exp_q[$];
  logic [15:0] got[$];
  logic        rdy_pat[$];
  logic        model_rr = 1'b1;

  logic        snap_valid;
  logic [15:0] snap_data;
  logic [1:0]  snap_grant;
  int          g0cnt, hdrcnt, pops0;

  logic        in_burst = 1'b0;
  logic        cur_src = 1'b0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = 16'h0;

  fx3_tx_arbiter #(.MAX_LEN(MAXL), .CW(3)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i),
    .s0_data_i(s0_data_i), .s0_valid_i(s0_valid_i), .s0_last_i(s0_last_i), .s0_ready_o(s0_ready_o),
    .s1_data_i(s1_data_i), .s1_valid_i(s1_valid_i), .s1_last_i(s1_last_i), .s1_ready_o(s1_ready_o),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  // Packet-level model: round-robin over non-empty queues, bursts of at most
  // MAXL words, each preceded by a header carrying the source ID.
  task automatic plan(input int nbursts);
    logic [16:0] a0[$];
    logic [16:0] a1[$];
    logic        src;
    logic [16:0] w;
    int          n;
    logic        e;
    a0 = q0;
    a1 = q1;
    for (int b = 0; b < nbursts; b++) begin
      if (a0.size() == 0 && a1.size() == 0) break;
      if (a0.size() > 0 && a1.size() > 0) src = ~model_rr;
      else src = (a1.size() > 0);
      exp_q.push_back('{hdr: 1'b1, eob: 1'b0, src: src, data: {4'hA, 3'b000, src, 8'h00}});
      n = 0;
      e = 1'b0;
      while (!e && ((src ? a1.size() : a0.size()) > 0)) begin
        w = src ? a1.pop_front() : a0.pop_front();
        n++;
        e = w[16] || (n == MAXL);
        exp_q.push_back('{hdr: 1'b0, eob: e, src: src, data: w[15:0]});
      end
      model_rr = src;
    end
  endtask

  task automatic drive_srcs();
    s0_valid_i = (q0.size() > 0);
    s0_data_i  = (q0.size() > 0) ? q0[0][15:0] : 16'h0;
    s0_last_i  = (q0.size() > 0) ? q0[0][16] : 1'b0;
    s1_valid_i = (q1.size() > 0);
    s1_data_i  = (q1.size() > 0) ? q1[0][15:0] : 16'h0;
    s1_last_i  = (q1.size() > 0) ? q1[0][16] : 1'b0;
  endtask

  task automatic step();
    logic t0, t1;
    @(negedge clk);
    snap_valid = m_valid_o;
    snap_data  = m_data_o;
    snap_grant = grant_o;
    if (grant_o == 2'b01) g0cnt++;
    if (m_valid_o && m_data_o == 16'hA000) hdrcnt++;
    t0 = s0_valid_i & s0_ready_o;
    t1 = s1_valid_i & s1_ready_o;
    @(posedge clk);
    #1;
    if (t0) begin void'(q0.pop_front()); pops0++; end
    if (t1) void'(q1.pop_front());
    if (rdy_pat.size() > 0) m_ready_i = rdy_pat.pop_front();
    drive_srcs();
  endtask

  task automatic run_until_done(input int budget);
    int c = 0;
    while (!(exp_q.size() == 0 && grant_o == 2'b00) && c < budget) begin
      step();
      c++;
    end
    if (c >= budget) fail_now("run_timeout");
    chk("exp_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Cycle-by-cycle comparison of the output stream against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", {11'b0, m_valid_o, m_data_o, s0_ready_o, s1_ready_o, grant_o, busy_o}, 32'd0);
      exp_q.delete();
      in_burst   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("busy_vs_grant", 32'(busy_o), 32'(grant_o != 2'b00));
      chk("grant_onehot", 32'(grant_o == 2'b11), 32'd0);
      chk("ready_exclusive", 32'(s0_ready_o & s1_ready_o), 32'd0);
      if (prev_stall) chk("hold_stable", {15'b0, m_valid_o, m_data_o}, {15'b0, 1'b1, prev_data});
      if (in_burst) begin
        chk("grant_in_data", 32'(grant_o), 32'({cur_src, ~cur_src}));
        chk("sel_ready", 32'(cur_src ? s1_ready_o : s0_ready_o), 32'(m_ready_i));
        chk("other_ready", 32'(cur_src ? s0_ready_o : s1_ready_o), 32'd0);
      end
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 32'(m_valid_o), 32'd0);
      end else if (m_valid_o) begin
        chk("stream_word", 32'(m_data_o), 32'(exp_q[0].data));
        if (exp_q[0].hdr) chk("hdr_grant", 32'(grant_o), 32'({exp_q[0].src, ~exp_q[0].src}));
        if (m_ready_i) begin
          got.push_back(m_data_o);
          if (exp_q[0].hdr) begin
            in_burst = 1'b1;
            cur_src  = exp_q[0].src;
          end
          if (exp_q[0].eob) in_burst = 1'b0;
          void'(exp_q.pop_front());
        end
      end
      prev_stall = m_valid_o & ~m_ready_i;
      prev_data  = m_data_o;
    end
  end

  initial begin
    logic [15:0] e1[5] = '{16'hA000, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
    logic [15:0] e3[8] = '{16'hA100, 16'h0301, 16'h0302, 16'h0303, 16'h0304, 16'hA100, 16'h0305, 16'h0306};
    logic [15:0] e4[3] = '{16'hA000, 16'h0401, 16'h0402};
    logic [15:0] e5[4] = '{16'hA100, 16'h0611, 16'h0612, 16'h0613};
    logic [15:0] e6[5] = '{16'hA000, 16'h0703, 16'h0704, 16'hA100, 16'h0801};
    int b;

    rst_n = 1'b0; en_i = 1'b0; m_ready_i = 1'b0;
    s0_data_i = 16'h0; s0_valid_i = 1'b0; s0_last_i = 1'b0;
    s1_data_i = 16'h0; s1_valid_i = 1'b0; s1_last_i = 1'b0;
    g0cnt = 0; hdrcnt = 0; pops0 = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single source, last coincides with the MAX_LEN boundary.
    en_i = 1'b1; m_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) q0.push_back({(i == 4), 16'(i)});
    got.delete(); g0cnt = 0;
    plan(99);
    drive_srcs();
    step();
    chk("latency_idle_valid", 32'(snap_valid), 32'd0);
    step();
    chk("first_header", {13'b0, snap_valid, snap_data, snap_grant}, {13'b0, 1'b1, 16'hA000, 2'b01});
    run_until_done(100);
    chk("single_len", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk("single_word", 32'(got[i]), 32'(e1[i]));
    chk("single_grant_cycles", 32'(g0cnt), 32'd5);

    // Round robin, both sources continuously valid with 2-word packets.
    for (int i = 0; i < 6; i++) begin
      q0.push_back({(i % 2 == 1), 16'h0101 + 16'(i)});
      q1.push_back({(i % 2 == 1), 16'h0201 + 16'(i)});
    end
    got.delete();
    plan(99);
    drive_srcs();
    run_until_done(200);
    chk("rr_len", 32'(got.size()), 32'd18);
    for (int k = 0; k < 6; k++) chk("rr_header", 32'(got[3*k]), (k % 2 == 1) ? 32'h0000A000 : 32'h0000A100);

    // Length cut at MAX_LEN with a 6-word packet.
    for (int i = 0; i < 6; i++) q1.push_back({(i == 5), 16'h0301 + 16'(i)});
    got.delete();
    plan(99);
    drive_srcs();
    run_until_done(100);
    chk("cut_len", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk("cut_word", 32'(got[i]), 32'(e3[i]));

    // Backpressure on header and data.
    q0.push_back({1'b0, 16'h0401});
    q0.push_back({1'b1, 16'h0402});
    rdy_pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    got.delete(); hdrcnt = 0;
    plan(99);
    drive_srcs();
    run_until_done(100);
    chk("bp_len", 32'(got.size()), 32'd3);
    for (int i = 0; i < 3; i++) chk("bp_word", 32'(got[i]), 32'(e4[i]));
    chk("bp_hdr_cycles", 32'(hdrcnt), 32'd3);

    // Enable low: no grant despite requests.
    en_i = 1'b0;
    q0.push_back({1'b1, 16'h0501});
    q1.push_back({1'b1, 16'h0601});
    drive_srcs();
    repeat (5) begin
      step();
      chk("en_off_grant", 32'(snap_grant), 32'd0);
    end
    q0.delete(); q1.delete();
    drive_srcs();

    // Enable dropped mid-burst: burst completes, nothing follows.
    en_i = 1'b1;
    q1.push_back({1'b0, 16'h0611});
    q1.push_back({1'b0, 16'h0612});
    q1.push_back({1'b1, 16'h0613});
    q0.push_back({1'b1, 16'h0511});
    got.delete();
    plan(1);
    drive_srcs();
    step();
    step();
    en_i = 1'b0;
    run_until_done(100);
    for (int i = 0; i < 4; i++) chk("en_drop_word", 32'(got[i]), 32'(e5[i]));
    repeat (4) begin
      step();
      chk("en_drop_no_grant", 32'(snap_grant), 32'd0);
    end
    chk("en_drop_s0_pending", 32'(q0.size()), 32'd1);
    q0.delete();
    drive_srcs();

    // Reset in the middle of a burst.
    en_i = 1'b1;
    for (int i = 0; i < 4; i++) q0.push_back({(i == 3), 16'h0701 + 16'(i)});
    q1.push_back({1'b1, 16'h0801});
    plan(99);
    drive_srcs();
    pops0 = 0;
    b = 0;
    while (pops0 < 2 && b < 50) begin
      step();
      b++;
    end
    if (b >= 50) fail_now("reset_wait");
    rst_n = 1'b0;
    #1;
    chk("reset_immediate", {11'b0, m_valid_o, m_data_o, s0_ready_o, s1_ready_o, grant_o, busy_o}, 32'd0);
    model_rr = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    got.delete();
    plan(99);
    drive_srcs();
    run_until_done(100);
    chk("post_reset_len", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk("post_reset_word", 32'(got[i]), 32'(e6[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
